// File: rtl/pic_uart_loader_if.sv
// Program-memory write port between the UART boot loader and the PIC16F54 core.
interface pic_uart_loader_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WORD_W = 12
);
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [WORD_W-1:0] pm_wdata;

    modport master (output pm_we, output pm_addr, output pm_wdata);
    modport slave  (input  pm_we, input  pm_addr, input  pm_wdata);
endinterface

// File: rtl/pic_uart_loader.sv
// UART boot loader for the PIC16F54 core: receives a framed image
// (A5, CNT_LO, CNT_HI, CNT x {LO, HI}, CSUM), writes 12-bit words into program
// memory and holds the core in reset until a frame completes with a good checksum.
// Optional feature macro: LOADER_BOOT_HOLD_EN (cpu_rst resets high and stays high
// until the first good load; otherwise cpu_rst resets low).
module pic_uart_loader #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WORD_W = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    pic_uart_loader_if.master         pm,
    output logic                      cpu_rst,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

`ifdef LOADER_BOOT_HOLD_EN
    localparam logic CPU_RST_INIT = 1'b1;
`else
    localparam logic CPU_RST_INIT = 1'b0;
`endif

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q, rx_ferr_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // Receiver next state: half-bit start check, then mid-bit samples DIV apart.
    always_comb begin
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    baud_cnt_d = CNT_W'(HALF - 1);
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (baud_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = RxIdle;  // glitch
                    end else begin
                        baud_cnt_d = CNT_W'(DIV - 1);
                        bit_idx_d  = '0;
                        rx_state_d = RxData;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            RxData: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = {rx_sync_q, shift_q[7:1]};
                    baud_cnt_d = CNT_W'(DIV - 1);
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            RxStop: begin
                if (baud_cnt_q == '0) begin
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                    rx_state_d = RxIdle;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser / loader
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle, StCntLo, StCntHi, StDatLo, StDatHi, StCsum, StDone, StErr
    } ld_state_e;

    ld_state_e         state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [9:0]        remain_q, remain_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        sum_q, sum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              go_err;
    logic [9:0]        cnt_full;

    assign cnt_full = {shift_q[1:0], cnt_lo_q};

    // Loader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_lo_q  <= '0;
            remain_q  <= '0;
            lo_q      <= '0;
            sum_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= CPU_RST_INIT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_lo_q  <= cnt_lo_d;
            remain_q  <= remain_d;
            lo_q      <= lo_d;
            sum_q     <= sum_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Loader next state: one step per received byte, abort on any violation.
    always_comb begin
        state_d   = state_q;
        cnt_lo_d  = cnt_lo_q;
        remain_d  = remain_q;
        lo_d      = lo_q;
        sum_d     = sum_q;
        we_d      = 1'b0;
        addr_d    = we_q ? addr_q + 1'b1 : addr_q;  // advance after each strobe
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        go_err    = 1'b0;

        if (rx_ferr_q) begin
            go_err = !(state_q inside {StIdle, StDone, StErr});
        end else if (rx_valid_q) begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (shift_q == 8'hA5) begin
                        state_d   = StCntLo;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                        cpu_rst_d = 1'b1;
                        sum_d     = '0;
                        addr_d    = '0;
                    end
                end
                StCntLo: begin
                    cnt_lo_d = shift_q;
                    sum_d    = sum_q + shift_q;
                    state_d  = StCntHi;
                end
                StCntHi: begin
                    sum_d = sum_q + shift_q;
                    if (shift_q[7:2] != '0 || cnt_full == '0 || cnt_full > 10'd512) begin
                        go_err = 1'b1;
                    end else begin
                        remain_d = cnt_full;
                        state_d  = StDatLo;
                    end
                end
                StDatLo: begin
                    lo_d    = shift_q;
                    sum_d   = sum_q + shift_q;
                    state_d = StDatHi;
                end
                StDatHi: begin
                    if (shift_q[7:4] != '0) begin
                        go_err = 1'b1;
                    end else begin
                        we_d     = 1'b1;
                        wdata_d  = WORD_W'({shift_q[3:0], lo_q});
                        sum_d    = sum_q + shift_q;
                        remain_d = remain_q - 1'b1;
                        state_d  = (remain_q == 10'd1) ? StCsum : StDatLo;
                    end
                end
                StCsum: begin
                    if (shift_q == sum_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        cpu_rst_d = 1'b0;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (go_err) begin
            state_d   = StErr;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            cpu_rst_d = 1'b1;
        end
    end

    assign pm.pm_we    = we_q;
    assign pm.pm_addr  = addr_q;
    assign pm.pm_wdata = wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
